// File: rtl/k12a_sequencer.sv
// K12a sequencer: state register, skip flag, instruction register and debug halt/resume/single-step.
// Optional retired-instruction counter enabled by defining K12A_RETIRE_COUNTER_EN.
package k12a_sequencer_pkg;
  typedef enum logic [2:0] {
    STATE_FETCH1 = 3'd0,
    STATE_FETCH2 = 3'd1,
    STATE_FETCH3 = 3'd2,
    STATE_EXEC   = 3'd3,
    STATE_RJMP   = 3'd4,
    STATE_HALT   = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    SKIP_SEL_0                  = 2'd0,
    SKIP_SEL_CONDITION          = 2'd1,
    SKIP_SEL_CONDITION_INVERTED = 2'd2
  } skip_sel_t;
endpackage

module k12a_sequencer
  import k12a_sequencer_pkg::*;
#(
  parameter int unsigned RETIRE_WIDTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  state_t      next_state,
  input  skip_sel_t   skip_sel,
  input  logic        skip_store,
  input  logic        alu_condition,
  input  logic        inst_high_store,
  input  logic        inst_low_store,
  input  logic [7:0]  data_bus,
  input  logic        halt_req,
  input  logic        resume,
  output state_t      state,
  output logic        skip,
  output logic [15:0] inst,
  output logic        halted
`ifdef K12A_RETIRE_COUNTER_EN
  ,
  output logic [RETIRE_WIDTH-1:0] retired
`endif
);

  if (RETIRE_WIDTH == 0) begin : g_bad_width
    $error("RETIRE_WIDTH must be nonzero");
  end

  state_t state_nx;
  logic   halt_pending;
  logic   pending_nx;
  logic   skip_nx;

  always_comb begin
    skip_nx = 1'b0;
    case (skip_sel)
      SKIP_SEL_CONDITION:          skip_nx = alu_condition;
      SKIP_SEL_CONDITION_INVERTED: skip_nx = ~alu_condition;
      default:                     skip_nx = 1'b0;
    endcase
  end

  // Halt is only taken where the control logic asks for FETCH1, so the
  // running instruction (including any RJMP cycle) always completes first.
  always_comb begin
    state_nx   = next_state;
    pending_nx = halt_pending;
    if (state == STATE_HALT) begin
      if (resume) begin
        state_nx   = STATE_FETCH1;
        pending_nx = halt_req;
      end else begin
        state_nx   = STATE_HALT;
      end
    end else if (next_state == STATE_FETCH1 && (halt_pending || halt_req)) begin
      state_nx   = STATE_HALT;
      pending_nx = 1'b0;
    end else if (next_state == STATE_HALT) begin
      pending_nx = 1'b0;
    end else if (halt_req) begin
      pending_nx = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= STATE_FETCH1;
      halt_pending <= 1'b0;
      skip         <= 1'b0;
      inst         <= '0;
    end else begin
      state        <= state_nx;
      halt_pending <= pending_nx;
      if (skip_store)      skip       <= skip_nx;
      if (inst_high_store) inst[15:8] <= data_bus;
      if (inst_low_store)  inst[7:0]  <= data_bus;
    end
  end

  assign halted = (state == STATE_HALT);

`ifdef K12A_RETIRE_COUNTER_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      retired <= '0;
    end else if (state == STATE_EXEC) begin
      retired <= retired + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_k12a_sequencer.sv
// Self-checking bench for k12a_sequencer: directed scenarios then random traffic,
// compared every cycle against a rule-level reference model.
module tb_k12a_sequencer;
  import k12a_sequencer_pkg::*;

  localparam int unsigned RW = 4;

  logic        clk = 1'b0;
  logic        reset;
  state_t      next_state;
  skip_sel_t   skip_sel;
  logic        skip_store;
  logic        alu_condition;
  logic        inst_high_store;
  logic        inst_low_store;
  logic [7:0]  data_bus;
  logic        halt_req;
  logic        resume;
  state_t      state;
  logic        skip;
  logic [15:0] inst;
  logic        halted;
`ifdef K12A_RETIRE_COUNTER_EN
  logic [RW-1:0] retired;
`endif

  k12a_sequencer #(.RETIRE_WIDTH(RW)) dut (
    .clk             (clk),
    .reset           (reset),
    .next_state      (next_state),
    .skip_sel        (skip_sel),
    .skip_store      (skip_store),
    .alu_condition   (alu_condition),
    .inst_high_store (inst_high_store),
    .inst_low_store  (inst_low_store),
    .data_bus        (data_bus),
    .halt_req        (halt_req),
    .resume          (resume),
    .state           (state),
    .skip            (skip),
    .inst            (inst),
    .halted          (halted)
`ifdef K12A_RETIRE_COUNTER_EN
    ,
    .retired         (retired)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: architectural view of the sequencer.
  state_t      m_state;
  logic        m_skip;
  logic [15:0] m_inst;
  logic        m_pend;
  int          m_ret;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic rst, input state_t ns, input skip_sel_t ss, input logic st,
                       input logic alu, input logic hs, input logic ls, input logic [7:0] db,
                       input logic hr, input logic rs);
    if (rst) begin
      m_state = STATE_FETCH1; m_skip = 0; m_inst = 16'h0000; m_pend = 0; m_ret = 0;
      return;
    end
    if (hs) m_inst = {db, m_inst[7:0]};
    if (ls) m_inst = {m_inst[15:8], db};
    if (st) m_skip = (ss == SKIP_SEL_CONDITION) ? alu :
                     (ss == SKIP_SEL_CONDITION_INVERTED) ? !alu : 1'b0;
    if (m_state == STATE_EXEC) m_ret = (m_ret + 1) % (1 << RW);
    if (m_state == STATE_HALT) begin
      if (rs) begin
        m_state = STATE_FETCH1;
        m_pend  = hr;
      end
    end else if (ns == STATE_FETCH1 && (m_pend || hr)) begin
      m_state = STATE_HALT;
      m_pend  = 0;
    end else begin
      m_state = ns;
      m_pend  = (ns == STATE_HALT) ? 1'b0 : (m_pend | hr);
    end
  endtask

  task automatic step(input logic rst, input state_t ns,
                      input skip_sel_t ss = SKIP_SEL_0, input logic st = 0, input logic alu = 0,
                      input logic hs = 0, input logic ls = 0, input logic [7:0] db = 8'h00,
                      input logic hr = 0, input logic rs = 0);
    reset = rst; next_state = ns; skip_sel = ss; skip_store = st; alu_condition = alu;
    inst_high_store = hs; inst_low_store = ls; data_bus = db; halt_req = hr; resume = rs;
    model(rst, ns, ss, st, alu, hs, ls, db, hr, rs);
    @(posedge clk);
    #1;
    chk("state", 32'(state), 32'(m_state));
    chk("skip", 32'(skip), 32'(m_skip));
    chk("inst", 32'(inst), 32'(m_inst));
    chk("halted", 32'(halted), 32'(m_state == STATE_HALT));
`ifdef K12A_RETIRE_COUNTER_EN
    chk("retired", 32'(retired), 32'(m_ret));
`endif
  endtask

  task automatic run_instr(input logic skipped);
    step(0, STATE_FETCH2);
    step(0, STATE_FETCH3);
    if (skipped) begin
      step(0, STATE_FETCH1, SKIP_SEL_0, 1);
    end else begin
      step(0, STATE_EXEC);
      step(0, STATE_FETCH1);
    end
  endtask

  int ret_before;
  state_t ns_r;

  initial begin
    m_state = STATE_FETCH1; m_skip = 0; m_inst = '0; m_pend = 0; m_ret = 0;
    @(negedge clk);
    step(1, STATE_FETCH1);
    chk("reset_state", 32'(state), 32'(STATE_FETCH1));
    chk("reset_halted", 32'(halted), 32'd0);

    // Build up skip=1, inst=ABCD, reach EXEC, then reset.
    step(0, STATE_FETCH2, SKIP_SEL_CONDITION, 1, 1, 1, 0, 8'hAB);
    step(0, STATE_FETCH3, SKIP_SEL_0, 0, 0, 0, 1, 8'hCD);
    step(0, STATE_EXEC);
    chk("pre_reset_inst", 32'(inst), 32'h0000ABCD);
    chk("pre_reset_skip", 32'(skip), 32'd1);
    step(1, STATE_RJMP);
    chk("reset_inst", 32'(inst), 32'h0);
    chk("reset_skip", 32'(skip), 32'd0);
    chk("reset_state2", 32'(state), 32'(STATE_FETCH1));

    // Byte-wise instruction load and the plain fetch sequence.
    step(0, STATE_FETCH2, SKIP_SEL_0, 0, 0, 1, 0, 8'h12);
    chk("seq_f2", 32'(state), 32'(STATE_FETCH2));
    step(0, STATE_FETCH3, SKIP_SEL_0, 0, 0, 0, 1, 8'h34);
    chk("inst_1234", 32'(inst), 32'h00001234);
    step(0, STATE_EXEC);
    chk("seq_exec", 32'(state), 32'(STATE_EXEC));
    step(0, STATE_FETCH1);
    chk("seq_f1", 32'(state), 32'(STATE_FETCH1));
    step(0, STATE_FETCH2, SKIP_SEL_0, 0, 0, 1, 1, 8'h5A);
    chk("both_bytes", 32'(inst), 32'h00005A5A);

    // Skip flag sources and hold.
    step(0, STATE_FETCH3, SKIP_SEL_CONDITION_INVERTED, 1, 0);
    chk("skip_inv", 32'(skip), 32'd1);
    step(0, STATE_EXEC, SKIP_SEL_0, 1, 1);
    chk("skip_zero", 32'(skip), 32'd0);
    step(0, STATE_FETCH1, SKIP_SEL_CONDITION, 0, 1);
    step(0, STATE_FETCH2, SKIP_SEL_CONDITION, 0, 0);
    chk("skip_hold", 32'(skip), 32'd0);
    step(0, STATE_FETCH3, skip_sel_t'(2'd3), 1, 1);
    chk("skip_sel3", 32'(skip), 32'd0);
    step(0, STATE_EXEC);
    step(0, STATE_FETCH1);

    // halt_req in FETCH2 of an rjmp: RJMP completes, then halt.
    step(0, STATE_FETCH2);
    step(0, STATE_FETCH3, SKIP_SEL_0, 0, 0, 0, 0, 8'h00, 1);
    step(0, STATE_EXEC);
    step(0, STATE_RJMP);
    chk("rjmp_seen", 32'(state), 32'(STATE_RJMP));
    step(0, STATE_FETCH1);
    chk("halt_entered", 32'(state), 32'(STATE_HALT));
    chk("halted_high", 32'(halted), 32'd1);
    for (int i = 0; i < 10; i++) step(0, STATE_FETCH1);
    chk("stay_halted", 32'(halted), 32'd1);

    // Single-step: one full instruction, then halt again.
    ret_before = m_ret;
    step(0, STATE_FETCH1, SKIP_SEL_0, 0, 0, 0, 0, 8'h00, 1, 1);
    chk("ss_f1", 32'(state), 32'(STATE_FETCH1));
    step(0, STATE_FETCH2);
    step(0, STATE_FETCH3);
    step(0, STATE_EXEC);
    chk("ss_exec", 32'(state), 32'(STATE_EXEC));
    step(0, STATE_FETCH1);
    chk("ss_rehalt", 32'(state), 32'(STATE_HALT));
`ifdef K12A_RETIRE_COUNTER_EN
    chk("ss_retired", 32'(retired), 32'((ret_before + 1) % (1 << RW)));
`endif
    step(0, STATE_FETCH2, SKIP_SEL_0, 0, 0, 0, 0, 8'h00, 0, 1);
    chk("resume_f1", 32'(state), 32'(STATE_FETCH1));
    step(0, STATE_FETCH2, SKIP_SEL_0, 0, 0, 0, 0, 8'h00, 0, 1);
    chk("resume_ignored", 32'(state), 32'(STATE_FETCH2));
    step(0, STATE_FETCH3);
    step(0, STATE_EXEC);
    step(0, STATE_HALT);
    chk("halt_instr", 32'(state), 32'(STATE_HALT));
    step(0, STATE_FETCH1, SKIP_SEL_0, 0, 0, 0, 0, 8'h00, 0, 1);

    // 17 instructions from reset plus one skipped one.
    step(1, STATE_FETCH1);
    for (int i = 0; i < 17; i++) begin
      run_instr(0);
      if (i == 5) begin
        step(0, STATE_FETCH2, SKIP_SEL_CONDITION, 1, 1);
        step(0, STATE_FETCH3);
        step(0, STATE_FETCH1, SKIP_SEL_0, 1);
      end
    end
`ifdef K12A_RETIRE_COUNTER_EN
    chk("retired_wrap", 32'(retired), 32'h1);
`endif

    // Random traffic with a plausible control-logic next_state.
    for (int i = 0; i < 400; i++) begin
      case (m_state)
        STATE_FETCH1: ns_r = STATE_FETCH2;
        STATE_FETCH2: ns_r = STATE_FETCH3;
        STATE_FETCH3: ns_r = m_skip ? STATE_FETCH1 : STATE_EXEC;
        STATE_EXEC: begin
          case ($urandom_range(0, 9))
            0, 1:    ns_r = STATE_RJMP;
            2:       ns_r = STATE_HALT;
            default: ns_r = STATE_FETCH1;
          endcase
        end
        STATE_RJMP: ns_r = STATE_FETCH1;
        default:    ns_r = state_t'($urandom_range(0, 5));
      endcase
      step(($urandom_range(0, 99) == 0), ns_r, skip_sel_t'($urandom_range(0, 3)),
           1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom),
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 5) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
